// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage core.
// Produces stage register enables, bubble inserts and the IF/ID flush from
// load-use / branch-compare hazards, multiply occupancy of EX and data
// memory wait states, and keeps a saturating stall-cycle counter.
module hazard_controller #(
    parameter int AddressSize  = 5,
    parameter int MulLatency   = 4,
    parameter int CounterWidth = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressSize-1:0]  IDRs1,
    input  logic [AddressSize-1:0]  IDRs2,
    input  logic                    IDUsesRs2,
    input  logic                    IDIsBranch,
    input  logic                    IDBranchTaken,
    input  logic [AddressSize-1:0]  EXRegisterRd,
    input  logic                    EXRegWrite,
    input  logic                    EXMemRead,
    input  logic                    EXIsMul,
    input  logic [AddressSize-1:0]  MemRegisterRd,
    input  logic                    MemMemRead,
    input  logic                    MemMemAccess,
    input  logic                    dmemReady,
    input  logic                    clrStallCount,
    output logic                    PCWrite,
    output logic                    IFIDWrite,
    output logic                    IDEXWrite,
    output logic                    EXMEMWrite,
    output logic                    MEMWBWrite,
    output logic                    IDEXBubble,
    output logic                    EXMEMBubble,
    output logic                    IFIDFlush,
    output logic [CounterWidth-1:0] stallCycles,
    output logic [1:0]              state
);

    localparam int CntW = $clog2(MulLatency) + 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MulLatency - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         mul_cnt_q, mul_cnt_d;
    logic [CounterWidth-1:0] stall_q;

    logic ex_rd_nz, mem_rd_nz, ex_src_match, mem_src_match;
    logic load_use, br_ex, br_load, id_haz, mem_wait, mul_busy;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    assign ex_rd_nz      = (EXRegisterRd != '0);
    assign mem_rd_nz     = (MemRegisterRd != '0);
    assign ex_src_match  = ex_rd_nz &
                           ((EXRegisterRd == IDRs1) | (IDUsesRs2 & (EXRegisterRd == IDRs2)));
    // The branch comparator always reads both operands.
    assign mem_src_match = mem_rd_nz &
                           ((MemRegisterRd == IDRs1) | (MemRegisterRd == IDRs2));

    assign load_use = EXMemRead & ex_src_match;
    assign br_ex    = IDIsBranch & EXRegWrite & ex_src_match;
    // The MEM forwarding path carries ALU results only, so a load in MEM
    // cannot feed the ID-stage comparator yet.
    assign br_load  = IDIsBranch & MemMemRead & mem_src_match;
    assign id_haz   = load_use | br_ex | br_load;
    assign mem_wait = MemMemAccess & ~dmemReady;

    // Next state, multiply counter and all Mealy control outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        mul_busy    = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        EXMEMWrite  = 1'b1;
        MEMWBWrite  = 1'b1;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        IFIDFlush   = 1'b0;

        if (!rst) begin
            if (mem_wait) begin
                // Whole pipeline freezes; FSM and counter hold.
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMWrite = 1'b0;
                MEMWBWrite = 1'b0;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (EXIsMul && (MulLatency > 1)) begin
                            mul_busy  = 1'b1;
                            mul_cnt_d = CntLoad;
                            state_d   = MUL_WAIT;
                        end
                    end
                    MUL_WAIT: begin
                        if (mul_cnt_q > CntOne) begin
                            mul_busy  = 1'b1;
                            mul_cnt_d = mul_cnt_q - CntOne;
                        end else begin
                            // Release: EX/MEM captures the product this cycle.
                            mul_cnt_d = '0;
                            state_d   = RUN;
                        end
                    end
                    default: state_d = RUN;
                endcase

                if (mul_busy) begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEXWrite   = 1'b0;
                    EXMEMBubble = 1'b1;
                end else if (id_haz) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                end else if (IDBranchTaken) begin
                    IFIDFlush = 1'b1;
                end
            end
        end
    end

    // FSM state and multiply occupancy counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst || clrStallCount) begin
            stall_q <= '0;
        end else if (!PCWrite && (stall_q != '1)) begin
            stall_q <= stall_q + CounterWidth'(1);
        end
    end

    assign stallCycles = stall_q;
    assign state       = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: the driver applies one vector per
// cycle and queues its hand-computed response; a monitor compares on the
// falling edge.
module tb_hazard_controller;

    localparam int AW = 5;
    localparam int CW = 32;

    // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
    //  IDEXBubble, EXMEMBubble, IFIDFlush}
    localparam logic [7:0] ALL = 8'b11111_000;
    localparam logic [7:0] STL = 8'b00111_100;
    localparam logic [7:0] FLS = 8'b11111_001;
    localparam logic [7:0] MUL = 8'b00011_010;
    localparam logic [7:0] FRZ = 8'b00000_000;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic [1:0]  st;
        logic [CW-1:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] IDRs1, IDRs2, EXRegisterRd, MemRegisterRd;
    logic IDUsesRs2, IDIsBranch, IDBranchTaken;
    logic EXRegWrite, EXMemRead, EXIsMul;
    logic MemMemRead, MemMemAccess, dmemReady, clrStallCount;
    logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
    logic IDEXBubble, EXMEMBubble, IFIDFlush;
    logic [CW-1:0] stallCycles;
    logic [1:0] state;

    hazard_controller #(.AddressSize(AW), .MulLatency(4), .CounterWidth(CW)) dut (
        .clk(clk), .rst(rst),
        .IDRs1(IDRs1), .IDRs2(IDRs2), .IDUsesRs2(IDUsesRs2),
        .IDIsBranch(IDIsBranch), .IDBranchTaken(IDBranchTaken),
        .EXRegisterRd(EXRegisterRd), .EXRegWrite(EXRegWrite),
        .EXMemRead(EXMemRead), .EXIsMul(EXIsMul),
        .MemRegisterRd(MemRegisterRd), .MemMemRead(MemMemRead),
        .MemMemAccess(MemMemAccess), .dmemReady(dmemReady),
        .clrStallCount(clrStallCount),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
        .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite),
        .IDEXBubble(IDEXBubble), .EXMEMBubble(EXMEMBubble),
        .IFIDFlush(IFIDFlush), .stallCycles(stallCycles), .state(state)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0;
        IDRs1 = '0; IDRs2 = '0; IDUsesRs2 = 1'b0;
        IDIsBranch = 1'b0; IDBranchTaken = 1'b0;
        EXRegisterRd = '0; EXRegWrite = 1'b0; EXMemRead = 1'b0; EXIsMul = 1'b0;
        MemRegisterRd = '0; MemMemRead = 1'b0; MemMemAccess = 1'b0;
        dmemReady = 1'b1; clrStallCount = 1'b0;
    endtask

    // Queue the expected response for the inputs now applied, then move to
    // just after the next rising edge.
    task automatic step(input string name, input logic [7:0] ctl,
                        input logic [1:0] st, input int unsigned stall);
        exp_t e;
        e.name = name; e.ctl = ctl; e.st = st; e.stall = CW'(stall);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_in();
        EXMemRead = 1'b1; EXRegWrite = 1'b1; EXRegisterRd = 5'd5; IDRs1 = 5'd5;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [7:0] got;
                e = exp_q.pop_front();
                got = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
                       IDEXBubble, EXMEMBubble, IFIDFlush};
                n_vec++;
                if (got !== e.ctl || state !== e.st || stallCycles !== e.stall) begin
                    n_bad++;
                    $display("FAIL %s: got ctl=%b state=%0d stall=%0d, expected ctl=%b state=%0d stall=%0d",
                             e.name, got, state, stallCycles, e.ctl, e.st, e.stall);
                end
            end
        end
    end

    // Driver.
    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset forces all enables high even with a hazard present.
        idle(); rst = 1'b1; load_use_in();            step("reset_outputs", ALL, 0, 0);
        idle();                                        step("idle", ALL, 0, 0);

        // Load-use.
        idle(); load_use_in();                         step("load_use", STL, 0, 0);
        idle(); MemMemRead = 1'b1; MemMemAccess = 1'b1; MemRegisterRd = 5'd5; IDRs1 = 5'd5;
                                                       step("load_use_done", ALL, 0, 1);
        idle(); EXMemRead = 1'b1; EXRegisterRd = 5'd7; IDRs2 = 5'd7;
                                                       step("rs2_unused", ALL, 0, 1);
        idle(); EXMemRead = 1'b1; EXRegisterRd = 5'd7; IDRs2 = 5'd7; IDUsesRs2 = 1'b1;
                                                       step("rs2_used", STL, 0, 1);
        idle(); EXMemRead = 1'b1;                      step("load_x0", ALL, 0, 2);

        // Branch compare over an ALU result in EX.
        idle(); IDIsBranch = 1'b1; IDBranchTaken = 1'b1; IDUsesRs2 = 1'b1;
                IDRs1 = 5'd3; IDRs2 = 5'd4; EXRegWrite = 1'b1; EXRegisterRd = 5'd4;
                                                       step("br_ex", STL, 0, 2);
        idle(); IDIsBranch = 1'b1; IDBranchTaken = 1'b1; IDUsesRs2 = 1'b1;
                IDRs1 = 5'd3; IDRs2 = 5'd4; EXRegWrite = 1'b1;
                                                       step("br_ex_x0", FLS, 0, 3);
        idle(); IDIsBranch = 1'b1; IDBranchTaken = 1'b1; IDRs1 = 5'd3; IDRs2 = 5'd4;
                EXRegWrite = 1'b1; EXRegisterRd = 5'd9;
                                                       step("taken_flush", FLS, 0, 3);

        // Branch compare against a load in MEM.
        idle(); IDIsBranch = 1'b1; IDRs2 = 5'd6; MemMemRead = 1'b1; MemRegisterRd = 5'd6;
                                                       step("br_load_rs2", STL, 0, 3);
        idle(); IDIsBranch = 1'b1; MemMemRead = 1'b1;  step("br_load_x0", ALL, 0, 4);
        idle(); IDIsBranch = 1'b1; IDRs1 = 5'd6; MemRegisterRd = 5'd6;
                                                       step("mem_alu_fwd", ALL, 0, 4);

        // Load in EX feeding a branch: two stall cycles.
        idle(); IDIsBranch = 1'b1; IDRs1 = 5'd8; EXMemRead = 1'b1; EXRegWrite = 1'b1;
                EXRegisterRd = 5'd8;                   step("br_load_c1", STL, 0, 4);
        idle(); IDIsBranch = 1'b1; IDRs1 = 5'd8; MemMemRead = 1'b1; MemMemAccess = 1'b1;
                MemRegisterRd = 5'd8;                  step("br_load_c2", STL, 0, 5);
        idle(); IDIsBranch = 1'b1; IDBranchTaken = 1'b1; IDRs1 = 5'd8;
                                                       step("br_resolve", FLS, 0, 6);

        // Multiply, 4 cycles of EX occupancy; front-end requests masked.
        idle(); EXIsMul = 1'b1; IDIsBranch = 1'b1; IDBranchTaken = 1'b1;
                                                       step("mul_start", MUL, 0, 6);
        idle(); EXIsMul = 1'b1;                        step("mul_wait3", MUL, 1, 7);
        idle(); EXIsMul = 1'b1;                        step("mul_wait2", MUL, 1, 8);
        idle(); EXIsMul = 1'b1;                        step("mul_release", ALL, 1, 9);
        idle();                                        step("mul_after", ALL, 0, 9);

        // Multiply stretched by two data-memory wait cycles; release meets a hazard.
        idle(); EXIsMul = 1'b1;                        step("mulw_start", MUL, 0, 9);
        idle(); EXIsMul = 1'b1; MemMemAccess = 1'b1; dmemReady = 1'b0;
                                                       step("mulw_freeze1", FRZ, 1, 10);
        idle(); EXIsMul = 1'b1; MemMemAccess = 1'b1; dmemReady = 1'b0;
                                                       step("mulw_freeze2", FRZ, 1, 11);
        idle(); EXIsMul = 1'b1; MemMemAccess = 1'b1;   step("mulw_wait3", MUL, 1, 12);
        idle(); EXIsMul = 1'b1;                        step("mulw_wait2", MUL, 1, 13);
        idle(); EXIsMul = 1'b1; IDIsBranch = 1'b1; IDRs1 = 5'd10;
                EXRegWrite = 1'b1; EXRegisterRd = 5'd10;
                                                       step("mulw_release_haz", STL, 1, 14);
        idle();                                        step("mulw_after", ALL, 0, 15);

        // Wait state delays a multiply start; reset then aborts MUL_WAIT.
        idle(); EXIsMul = 1'b1; MemMemAccess = 1'b1; dmemReady = 1'b0;
                                                       step("wait_before_mul", FRZ, 0, 15);
        idle(); EXIsMul = 1'b1;                        step("mul_start2", MUL, 0, 16);
        idle(); EXIsMul = 1'b1;                        step("mul_wait_pre_rst", MUL, 1, 17);
        idle(); rst = 1'b1; EXIsMul = 1'b1;            step("rst_in_mul", ALL, 1, 18);
        idle();                                        step("after_rst", ALL, 0, 0);

        // Wait state outranks a load-use hazard.
        idle(); load_use_in(); MemMemAccess = 1'b1; dmemReady = 1'b0;
                                                       step("wait_over_haz", FRZ, 0, 0);
        idle();                                        step("wait_done", ALL, 0, 1);

        // Count up to 7, then clear.
        for (int i = 1; i <= 6; i++) begin
            idle(); load_use_in();                     step($sformatf("count_%0d", i), STL, 0, i);
        end
        idle(); clrStallCount = 1'b1;                  step("clr_at_7", ALL, 0, 7);
        idle();                                        step("cleared", ALL, 0, 0);
        idle(); load_use_in(); clrStallCount = 1'b1;   step("clr_over_inc", STL, 0, 0);
        idle();                                        step("clr_over_inc_chk", ALL, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage core. It generates per-stage register write enables, bubble inserts and the IF/ID flush. It detects load-use and branch-compare hazards, which operand forwarding cannot resolve, and sequences multi-cycle multiply occupancy of EX and data-memory wait states. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- AddressSize, 5, register index width
- MulLatency, 4, total cycles a multiply occupies EX (legal range ≥1)
- CounterWidth, 32, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- IDRs1, IDRs2  in  AddressSize  source registers of instruction in ID
- IDUsesRs2  in  1  ID instruction reads Rs2
- IDIsBranch  in  1  ID instruction is a conditional branch (compare in ID)
- IDBranchTaken  in  1  ID compare result, branch taken
- EXRegisterRd  in  AddressSize  destination of EX instruction
- EXRegWrite, EXMemRead, EXIsMul  in  1 each  EX control bits
- MemRegisterRd  in  AddressSize  destination of MEM instruction
- MemMemRead, MemMemAccess  in  1 each  MEM is a load / any load or store
- dmemReady  in  1  data memory completes access this cycle
- clrStallCount  in  1  synchronous clear of stallCycles
- PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite  out  1 each  pipeline register enables
- IDEXBubble  out  1  ID/EX loads all-zero control (nop)
- EXMEMBubble  out  1  EX/MEM loads all-zero control
- IFIDFlush  out  1  IF/ID loads nop
- stallCycles  out  CounterWidth  cycles with PCWrite=0
- state  out  2  debug: 0 RUN, 1 MUL_WAIT

## Operation
- Hazard terms (register 0 never matches):
  - loadUse = EXMemRead & EXRd≠0 & (EXRd==IDRs1 | IDUsesRs2 & EXRd==IDRs2).
  - brEX = IDIsBranch & EXRegWrite & EXRd≠0 & same match.
  - brLoad = IDIsBranch & MemMemRead & MemRd≠0 & (MemRd==IDRs1 | MemRd==IDRs2). MEM forwarding carries ALU results only.
  - idHaz = loadUse | brEX | brLoad.
- memWait = MemMemAccess & ~dmemReady. It has highest priority in any state.
  - All five Write outputs = 0; bubbles and flush = 0.
  - FSM state and multiply counter hold.
- FSM, 2 states, with a mulCnt counter of width clog2(MulLatency)+1:
  - RUN, EXIsMul & MulLatency>1 & ~memWait:
    - PCWrite = IFIDWrite = IDEXWrite = 0, EXMEMBubble = 1, EXMEMWrite = MEMWBWrite = 1.
    - mulCnt ← MulLatency-1; next state MUL_WAIT.
  - MUL_WAIT, mulCnt>1: same outputs as above; mulCnt decrements.
  - MUL_WAIT, mulCnt==1 (release): EX/MEM captures the multiply result; EXMEMBubble = 0; next state RUN. Front-end rules below apply.
  - Multiply occupies EX for exactly MulLatency cycles. With MulLatency=1 the FSM never leaves RUN.
- Front-end rules apply in RUN with no multiply start, or on the release cycle, with ~memWait:
  - idHaz: PCWrite = IFIDWrite = 0, IDEXBubble = 1. Later stages write.
  - Else IDBranchTaken: IFIDFlush = 1, all Write = 1.
  - Else: all Write = 1, bubbles and flush = 0.
- IFIDFlush is never asserted while IFIDWrite=0.
- stallCycles:
  - Increments on each cycle with PCWrite=0, saturating at all-ones.
  - clrStallCount has priority over increment; the counter reads 0 the next cycle.

## Timing
- All outputs except stallCycles and state are combinational from the current state, mulCnt and inputs (Mealy). There is no added latency.
- While rst=1: all Write outputs = 1, bubbles and flush = 0, regardless of inputs.
- On the first edge with rst=1: state=RUN, mulCnt=0, stallCycles=0.
- Reset asserted in MUL_WAIT aborts the sequence; RUN from the next cycle.
- A load-use stall lasts exactly 1 cycle.
- brLoad holds for 1 cycle, or 2 when the load is in EX at detection (loadUse, then brLoad).
- memWait during MUL_WAIT freezes mulCnt, which stretches occupancy by the wait cycles.

## Test plan
- Load-use: EX = lw x5 (EXMemRead=1, EXRd=5), ID reads Rs1=5 → one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle all Write=1; stallCycles=1.
- Branch over ALU result: ID beq x3,x4, EX add x4 (EXRegWrite=1) → 1-cycle stall. Same case with EXRd=0 → no stall.
- Taken branch with no hazard: IDBranchTaken=1 → IFIDFlush=1 for one cycle, PCWrite=1.
- Multiply, MulLatency=4: EXIsMul=1 → EXMEMBubble=1 and front end frozen for 3 cycles, release on the 4th, state back to 0; stallCycles=3.
- dmemReady=0 for 2 cycles with MemMemAccess=1, mid-multiply → all Write=0 for 2 cycles, mulCnt frozen; release delayed by 2 cycles.
- Reset asserted during MUL_WAIT → next cycle state=0, stallCycles=0, all Write=1. clrStallCount at a count of 7 → counter reads 0 the next cycle.
